clk_100khz: RTL and testbench

CLK_100KHZ -- requirements
Module: clk_100khz

---
 rtl/clk_100khz.sv | 59 +++++
 tb/tb_clk_100khz.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/clk_100khz.sv
// Clock divider: produces a 50% duty square wave at OUT_FREQ_HZ from clk_i.
// The output is taken straight from a flop, so it can never glitch. Between
// transitions a counter runs 0..HALF_PERIOD-1 and then reloads 0, so codes
// above HALF_PERIOD-1 are never visited.
module clk_100khz #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned OUT_FREQ_HZ = 100_000
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic k_o
);

    // Guarded so that a zero output frequency reaches the fatal check below
    // instead of dividing by zero first.
    localparam int unsigned HALF_PERIOD =
        (OUT_FREQ_HZ == 0) ? 1 : CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
    localparam int unsigned CNT_W =
        (HALF_PERIOD <= 1) ? 1 : $clog2(HALF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    // Reject frequency pairs that cannot give an exact 50% duty output.
    if (OUT_FREQ_HZ == 0) begin : g_err_zero
        $fatal(1, "clk_100khz: OUT_FREQ_HZ must be non-zero");
    end else if (2 * OUT_FREQ_HZ > CLK_FREQ_HZ) begin : g_err_fast
        $fatal(1, "clk_100khz: 2*OUT_FREQ_HZ exceeds CLK_FREQ_HZ");
    end else if (CLK_FREQ_HZ % (2 * OUT_FREQ_HZ) != 0) begin : g_err_ratio
        $fatal(1, "clk_100khz: CLK_FREQ_HZ is not a multiple of 2*OUT_FREQ_HZ");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             k_q,   k_d;

    // Next state: count up, or reload and flip the output at the end of a half period.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        cnt_d = cnt_q + 1'b1;
        k_d   = k_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            k_d   = ~k_q;
        end
    end

    // State register; reset clears counter and output immediately, without a clock.
    always_ff @(posedge clk_i or negedge reset_i) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!reset_i) begin
            cnt_q <= '0;
            k_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            k_q   <= k_d;
        end
    end

    assign k_o = k_q;

endmodule

// File: tb/tb_clk_100khz.sv
// Bench for clk_100khz: a default instance (half period 500) and a
// half-period-1 instance share clock and reset. The stimulus process keeps
// a count of edges since reset release and derives the expected outputs from
// it arithmetically, queuing them. A monitor pops one entry per cycle and
// compares it, and it also times the high and low phases of the default
// instance.
module tb_clk_100khz;

    localparam int HP_A = 500;   // 100 MHz / (2 * 100 kHz)
    localparam int HP_B = 1;     // 10 Hz / (2 * 5 Hz)

    typedef struct {
        int exp_a;
        int exp_b;
    } exp_t;

    logic clk;
    logic reset_i;
    logic k_a;
    logic k_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_edges  = 0;      // rising edges with reset sampled high since release
    int   n_phases = 0;      // completed phase-length measurements
    exp_t exp_q[$];

    clk_100khz u_dut_a (
        .clk_i   (clk),
        .reset_i (reset_i),
        .k_o     (k_a)
    );

    clk_100khz #(
        .CLK_FREQ_HZ (10),
        .OUT_FREQ_HZ (5)
    ) u_dut_b (
        .clk_i   (clk),
        .reset_i (reset_i),
        .k_o     (k_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Advance one clock; update the reference model and queue its prediction.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (reset_i) n_edges++;
        else         n_edges = 0;
        e.exp_a = (n_edges / HP_A) % 2;
        e.exp_b = (n_edges / HP_B) % 2;
        exp_q.push_back(e);
    endtask

    // Change reset between clock edges; an assertion must clear outputs at once.
    task automatic set_reset(input logic v);
        @(negedge clk);
        #2;
        reset_i = v;
        if (!v) begin
            n_edges = 0;
            #1;
            check("async_reset_a", int'(k_a), 0);
            check("async_reset_b", int'(k_b), 0);
        end
    endtask

    // Monitor: compare queued predictions and time phases of the default instance.
    initial begin
        exp_t e;
        logic prev_k     = 1'b0;
        bit   have_edge  = 1'b0;
        int   phase_len  = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("k_o_a", int'(k_a), e.exp_a);
                check("k_o_b", int'(k_b), e.exp_b);
            end
            if (!reset_i) begin
                have_edge = 1'b0;
                phase_len = 0;
            end else if (k_a != prev_k) begin
                if (have_edge) begin
                    check("phase_len", phase_len, HP_A);
                    n_phases++;
                end
                have_edge = 1'b1;
                phase_len = 1;
            end else begin
                phase_len++;
            end
            prev_k = k_a;
        end
    end

    // Stimulus: reset hold, long free run, mid-high reset, then random resets.
    initial begin
        int extra;
        reset_i = 1'b0;
        repeat (5) tick();

        set_reset(1'b1);
        repeat (10_500) tick();

        // Stop at cnt=250 in a high phase and abort it asynchronously.
        extra = (750 - (n_edges % 1000) + 1000) % 1000;
        repeat (extra) tick();
        set_reset(1'b0);
        repeat (3) tick();
        set_reset(1'b1);
        repeat (1100) tick();

        repeat (8) begin
            repeat ($urandom_range(2500, 1)) tick();
            set_reset(1'b0);
            repeat ($urandom_range(4, 1)) tick();
            set_reset(1'b1);
        end
        repeat (600) tick();

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("phases_seen", int'(n_phases >= 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
